spi_frame_loader: RTL



---
 rtl/spi_loader_pkg.sv | 26 ++
 rtl/spi_operand_bank.sv | 31 +++
 rtl/spi_frame_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spi_loader_pkg.sv
// Shared definitions for the SPI frame loader: header opcodes, FSM states, header field layout.
package spi_loader_pkg;

  typedef enum logic [1:0] {
    OP_WEIGHTS = 2'b00,
    OP_INPUTS  = 2'b01,
    OP_BIAS    = 2'b10,
    OP_START   = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int HDR_OP_LSB  = 6;
  localparam int HDR_OP_W    = 2;
  localparam int HDR_IDX_LSB = 0;
  localparam int HDR_IDX_W   = 6;

  // One bit wider than the header index so the pointer can sit at 64 without wrapping.
  localparam int PTR_W = HDR_IDX_W + 1;

endpackage

// File: rtl/spi_operand_bank.sv
// Indexed operand register file: single write port with range check, flat-bus read-out.
module spi_operand_bank #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int IDX_W    = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [DATA_W-1:0]            wdata,
  output logic                         in_range,
  output logic [N_INPUTS*DATA_W-1:0]   rdata
);

  logic [N_INPUTS*DATA_W-1:0] mem;

  assign in_range = idx < IDX_W'(N_INPUTS);
  assign rdata    = mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (we && idx == IDX_W'(i)) mem[i*DATA_W +: DATA_W] <= wdata;
      end
    end
  end

endmodule

// File: rtl/spi_frame_loader.sv
// Turns SPI frames into neuron operands and a compute-start pulse.
// Optional checksum/shadow-commit mode: define SPI_LOADER_CKSUM_EN.
//
// state    | meaning
// S_IDLE   | no frame open, waiting for chip-select to fall
// S_HEADER | frame open, waiting for the header byte
// S_DATA   | header latched, data bytes written at the pointer
// S_DONE   | one clk: frame closed, start / commit decided
module spi_frame_loader
  import spi_loader_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           byte_data,
  input  logic                        byte_valid,
  input  logic                        cs_idle,
  output logic [N_INPUTS*DATA_W-1:0]  weights,
  output logic [N_INPUTS*DATA_W-1:0]  inputs,
  output logic [DATA_W-1:0]           bias,
  output logic                        start,
  output logic                        frame_err,
  output logic                        busy
);

  state_e              state;
  opcode_e             op;
  logic [PTR_W-1:0]    ptr;
  logic                cs_q, hdr_seen;
  logic                cs_fall, cs_rise;
  logic                proc, wr_w, wr_i, wr_b, data_err;
  logic                rng_w, rng_i, cksum_bad;
  logic [DATA_W-1:0]   proc_byte, bias_wr;
  logic [N_INPUTS*DATA_W-1:0] w_bank, i_bank;

  // cs_q resets low so a frame cut by reset must see chip-select idle before reopening.
  assign cs_fall = cs_q & ~cs_idle;
  assign cs_rise = ~cs_q & cs_idle;

`ifdef SPI_LOADER_CKSUM_EN
  logic [DATA_W-1:0]          hold, cksum, bias_q;
  logic                       hold_vld, mask_b, commit;
  logic [N_INPUTS-1:0]        mask_w, mask_i;
  logic [N_INPUTS*DATA_W-1:0] weights_q, inputs_q;

  assign proc      = (state == S_DATA) && byte_valid && hold_vld;
  assign proc_byte = hold;
  assign cksum_bad = cksum != '0;
  assign commit    = (state == S_DONE) && hdr_seen && !cksum_bad && !frame_err;
  assign weights   = weights_q;
  assign inputs    = inputs_q;
  assign bias      = bias_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_vld  <= 1'b0;
      cksum     <= '0;
      mask_w    <= '0;
      mask_i    <= '0;
      mask_b    <= 1'b0;
      weights_q <= '0;
      inputs_q  <= '0;
      bias_q    <= '0;
    end else begin
      if (state == S_IDLE && cs_fall) begin
        hold_vld <= 1'b0;
        cksum    <= '0;
        mask_w   <= '0;
        mask_i   <= '0;
        mask_b   <= 1'b0;
      end else if ((state == S_HEADER || state == S_DATA) && byte_valid) begin
        cksum <= cksum ^ byte_data;
        if (state == S_DATA) begin
          hold     <= byte_data;
          hold_vld <= 1'b1;
        end
      end
      // Only elements written by this frame are copied out of the shadow banks.
      for (int i = 0; i < N_INPUTS; i++) begin
        if (wr_w && ptr == PTR_W'(i)) mask_w[i] <= 1'b1;
        if (wr_i && ptr == PTR_W'(i)) mask_i[i] <= 1'b1;
        if (commit && mask_w[i]) weights_q[i*DATA_W +: DATA_W] <= w_bank[i*DATA_W +: DATA_W];
        if (commit && mask_i[i]) inputs_q[i*DATA_W +: DATA_W]  <= i_bank[i*DATA_W +: DATA_W];
      end
      if (wr_b) mask_b <= 1'b1;
      if (commit && mask_b) bias_q <= bias_wr;
    end
  end
`else
  assign proc      = (state == S_DATA) && byte_valid;
  assign proc_byte = byte_data;
  assign cksum_bad = 1'b0;
  assign weights   = w_bank;
  assign inputs    = i_bank;
  assign bias      = bias_wr;
`endif

  always_comb begin
    wr_w     = 1'b0;
    wr_i     = 1'b0;
    wr_b     = 1'b0;
    data_err = 1'b0;
    if (proc) begin
      case (op)
        OP_WEIGHTS: begin wr_w = rng_w; data_err = !rng_w; end
        OP_INPUTS:  begin wr_i = rng_i; data_err = !rng_i; end
        OP_BIAS:    begin wr_b = (ptr == '0); data_err = (ptr != '0); end
        default:    data_err = 1'b1;
      endcase
    end
  end

  spi_operand_bank #(.N_INPUTS(N_INPUTS), .DATA_W(DATA_W), .IDX_W(PTR_W)) u_weights (
    .clk(clk), .rst_n(rst_n), .we(wr_w), .idx(ptr), .wdata(proc_byte),
    .in_range(rng_w), .rdata(w_bank)
  );

  spi_operand_bank #(.N_INPUTS(N_INPUTS), .DATA_W(DATA_W), .IDX_W(PTR_W)) u_inputs (
    .clk(clk), .rst_n(rst_n), .we(wr_i), .idx(ptr), .wdata(proc_byte),
    .in_range(rng_i), .rdata(i_bank)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias_wr <= '0;
    else if (wr_b) bias_wr <= proc_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op        <= OP_WEIGHTS;
      ptr       <= '0;
      cs_q      <= 1'b0;
      hdr_seen  <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cs_q  <= cs_idle;
      start <= 1'b0;
      if (proc && ptr != PTR_W'(64)) ptr <= ptr + PTR_W'(1);
      if (data_err) frame_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state    <= S_HEADER;
            busy     <= 1'b1;
            hdr_seen <= 1'b0;
          end
        end
        S_HEADER: begin
          if (byte_valid) begin
            op        <= opcode_e'(byte_data[HDR_OP_LSB +: HDR_OP_W]);
            ptr       <= (opcode_e'(byte_data[HDR_OP_LSB +: HDR_OP_W]) == OP_BIAS) ? '0
                         : {1'b0, byte_data[HDR_IDX_LSB +: HDR_IDX_W]};
            frame_err <= 1'b0;
            hdr_seen  <= 1'b1;
            state     <= S_DATA;
          end
          if (cs_rise) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DATA: begin
          if (cs_rise) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          if (hdr_seen && cksum_bad) frame_err <= 1'b1;
          start <= hdr_seen && (op == OP_START) && !frame_err && !cksum_bad;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
